// File: rtl/cnt_disp_pkg.sv
// cnt_disp_pkg: shared constants for the counter display stage.
//   SEG_LUT  - 16-entry seven-segment table, bit order {g,f,e,d,c,b,a}, active-high
//   DIGIT_W  - width of one displayed digit (4)
//   SEG_W    - width of the segment bus (7)
//   AN_*     - active-low digit-enable codes for units, tens and all-off
//   digit_sel_e - which digit the scan currently drives
package cnt_disp_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;

    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        SEL_UNITS = 1'b0,
        SEL_TENS  = 1'b1
    } digit_sel_e;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational 4-to-7 segment lookup.
//   digit - hex digit 0..F
//   seg   - segments {g,f,e,d,c,b,a}, active-high
module seg7_dec
    import cnt_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_LUT[digit];
    end

endmodule

// File: rtl/cnt_disp_scan.sv
// cnt_disp_scan: display stage behind the 4-bit enable/carry counter.
// Counts rising edges of the upstream carry into a tens digit and scans a
// two-digit, time-multiplexed seven-segment display (units from q_in, tens).
//   clk    - system clock, rising edge
//   mr     - master reset, synchronous, active-low
//   q_in   - upstream units value
//   co_in  - upstream carry, any pulse width (only the rising edge counts)
//   tens   - tens count, wraps after TENS_MAX
//   ovf    - one-cycle pulse on tens wrap to 0
//   an     - digit enables, active-low ([0] units, [1] tens)
//   seg    - segments {g,f,e,d,c,b,a}, active-high
// Parameters: SCAN_DIV (cycles per digit, >= 2), TENS_MAX (1..15).
// Build option: define CNT_DISP_LZ_BLANK_EN to blank a leading-zero tens digit.
module cnt_disp_scan
    import cnt_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int TENS_MAX = 9
) (
    input  logic               clk,
    input  logic               mr,
    input  logic [DIGIT_W-1:0] q_in,
    input  logic               co_in,
    output logic [DIGIT_W-1:0] tens,
    output logic               ovf,
    output logic [1:0]         an,
    output logic [SEG_W-1:0]   seg
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIGIT_W-1:0] TENS_LAST = DIGIT_W'(TENS_MAX);

    logic               co_d;
    logic               inc;
    logic [DIGIT_W-1:0] unit_r;
    logic [SCAN_W-1:0]  scan_cnt;
    digit_sel_e         sel;
    logic [DIGIT_W-1:0] digit;
    logic [SEG_W-1:0]   seg_dec;
    logic [SEG_W-1:0]   seg_next;

    always_comb begin
        inc = co_in & ~co_d;
    end

    always_comb begin
        digit = (sel == SEL_TENS) ? tens : unit_r;
    end

    seg7_dec u_dec (
        .digit (digit),
        .seg   (seg_dec)
    );

    always_comb begin
        seg_next = seg_dec;
`ifdef CNT_DISP_LZ_BLANK_EN
        if (sel == SEL_TENS && tens == '0) begin
            seg_next = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!mr) begin
            // co_d resets high so a carry still asserted at release is not counted
            co_d     <= 1'b1;
            tens     <= '0;
            ovf      <= 1'b0;
            unit_r   <= '0;
            scan_cnt <= '0;
            sel      <= SEL_UNITS;
            an       <= AN_OFF;
            seg      <= '0;
        end else begin
            co_d   <= co_in;
            unit_r <= q_in;
            ovf    <= 1'b0;
            if (inc) begin
                if (tens == TENS_LAST) begin
                    tens <= '0;
                    ovf  <= 1'b1;
                end else begin
                    tens <= tens + DIGIT_W'(1);
                end
            end
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                sel      <= (sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            an  <= (sel == SEL_TENS) ? AN_TENS : AN_UNITS;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_cnt_disp_scan.sv
module tb_cnt_disp_scan;

    localparam int D  = 4;
    localparam int TM = 9;

    logic       clk = 1'b0;
    logic       mr = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       co_in = 1'b0;
    logic [3:0] tens;
    logic       ovf;
    logic [1:0] an;
    logic [6:0] seg;

    int checks = 0;
    int failures = 0;

    cnt_disp_scan #(.SCAN_DIV(D), .TENS_MAX(TM)) dut (
        .clk   (clk),
        .mr    (mr),
        .q_in  (q_in),
        .co_in (co_in),
        .tens  (tens),
        .ovf   (ovf),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

`ifdef CNT_DISP_LZ_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: n counts edges since reset release; slot = (n-1)/D picks
    // the digit, units show the q_in seen one edge earlier, tens the count
    // held before this edge.
    bit         m_valid = 1'b0;
    int         m_n;
    int         m_tens;
    int         m_qprev;
    bit         m_prev_co;
    int         e_ovf, e_an, e_seg;

    always @(posedge clk) begin
        if (!mr) begin
            m_valid   = 1'b1;
            m_n       = 0;
            m_tens    = 0;
            m_qprev   = 0;
            m_prev_co = 1'b1;
            e_ovf     = 0;
            e_an      = 2'b11;
            e_seg     = 0;
        end else if (m_valid) begin
            int  old_tens;
            bit  on_tens;
            m_n++;
            on_tens  = (((m_n - 1) / D) % 2) == 1;
            old_tens = m_tens;
            e_ovf    = 0;
            if (co_in && !m_prev_co) begin
                if (m_tens == TM) begin
                    m_tens = 0;
                    e_ovf  = 1;
                end else begin
                    m_tens = m_tens + 1;
                end
            end
            m_prev_co = co_in;
            e_an  = on_tens ? 2'b01 : 2'b10;
            if (on_tens)
                e_seg = (BLANK && old_tens == 0) ? 0 : int'(lut[old_tens]);
            else
                e_seg = int'(lut[m_qprev]);
            m_qprev = int'(q_in);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tens", int'(tens), m_tens);
            chk("ovf",  int'(ovf),  e_ovf);
            chk("an",   int'(an),   e_an);
            chk("seg",  int'(seg),  e_seg);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ovf_seen;
        bit found;
        @(negedge clk);

        // Reset with carry held high
        mr = 1'b0; co_in = 1'b1; q_in = 4'd0;
        cyc(3);
        chk("rst_tens", int'(tens), 0);
        chk("rst_ovf",  int'(ovf),  0);
        chk("rst_an",   int'(an),   2'b11);
        chk("rst_seg",  int'(seg),  0);

        // Release with carry still high: no increment
        mr = 1'b1;
        cyc(1);
        chk("rel_an",   int'(an),   2'b10);
        chk("rel_seg",  int'(seg),  7'h3F);
        chk("rel_tens", int'(tens), 0);
        cyc(1);
        co_in = 1'b0;

        // Scan with constant units value
        q_in = 4'd7;
        cyc(16);

        // Held carry: one increment only
        co_in = 1'b1;
        cyc(1);
        chk("hold_first", int'(tens), 1);
        cyc(5);
        chk("hold_end", int'(tens), 1);
        co_in = 1'b0;
        cyc(2);

        // Wrap: ten single-cycle pulses from 0
        mr = 1'b0; cyc(1); mr = 1'b1; cyc(1);
        ovf_seen = 0;
        for (int i = 0; i < 10; i++) begin
            co_in = 1'b1; cyc(1);
            chk("wrap_tens", int'(tens), (i + 1) % 10);
            if (ovf) ovf_seen++;
            co_in = 1'b0; cyc(1);
            if (ovf) ovf_seen++;
        end
        chk("wrap_ovf_count", ovf_seen, 1);

        // Reset coinciding with a carry edge at tens=5
        for (int i = 0; i < 5; i++) begin
            co_in = 1'b1; cyc(1);
            co_in = 1'b0; cyc(1);
        end
        chk("mid_pre", int'(tens), 5);
        co_in = 1'b1; mr = 1'b0;
        cyc(1);
        chk("mid_tens", int'(tens), 0);
        chk("mid_ovf",  int'(ovf),  0);
        mr = 1'b1; co_in = 1'b0;
        cyc(1);

        // Hex digit in units slot
        q_in = 4'hC;
        cyc(10);
        found = 1'b0;
        for (int i = 0; i < 2 * D && !found; i++) begin
            if (an == 2'b10) begin
                chk("hex_seg", int'(seg), 7'h39);
                found = 1'b1;
            end else begin
                cyc(1);
            end
        end
        if (!found) chk("hex_slot_timeout", 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            q_in  = 4'($urandom_range(0, 15));
            co_in = ($urandom_range(0, 2) == 0) ? ~co_in : co_in;
            mr    = ($urandom_range(0, 59) != 0);
            cyc(1);
        end
        mr = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_disp_scan.md
# cnt_disp_scan

Downstream display stage for the 4-bit enable/carry counter. It accepts the counter's value `q` and carry `co` and detects rising edges of `co` to keep a tens digit. It drives a two-digit, time-multiplexed seven-segment display showing the tens digit and the counter's units digit. It shares the counter's clock and master-reset net.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `TENS_MAX`, default 9: last tens value before wrap; legal range 1..15.

Ports:
- `clk`, in, 1: single system clock; all state updates on the rising edge.
- `mr`, in, 1: master reset; synchronous and active-low.
- `q_in`, in, 4: units value from the upstream counter (`q`).
- `co_in`, in, 1: carry from the upstream counter (`co`); any pulse width.
- `tens`, out, 4: current tens count.
- `ovf`, out, 1: one-cycle pulse when `tens` wraps from `TENS_MAX` to 0.
- `an`, out, 2: digit enables, active-low.
  - `an[0]` is units; `an[1]` is tens.
- `seg`, out, 7: segments `{g,f,e,d,c,b,a}`, active-high.

## Operation
- Carry detect:
  - Register `co_d <= co_in` every cycle.
  - Increment event = `co_in & ~co_d`.
  - A `co_in` level held high for N cycles produces exactly one increment.
- Tens counter:
  - On an increment event, `tens <= (tens == TENS_MAX) ? 0 : tens + 1`.
  - On wrap, `ovf` is 1 for that single cycle; otherwise `ovf` is 0.
  - `tens` is 4-bit unsigned with no saturation.
- Units capture: `unit_r <= q_in` every cycle, with no qualification.
- Scan:
  - `scan_cnt` counts 0..`SCAN_DIV`-1 and wraps.
  - On the wrap cycle, `sel` toggles. `sel`=0 selects units; `sel`=1 selects tens.
- Output stage (registered):
  - `an <= sel ? 2'b01 : 2'b10`.
  - `seg <= decode(sel ? tens : unit_r)`.
- Decode, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex).
  - Upstream values 10..15 display as A..F.
- Reset, when `mr`=0 at a clock edge (overrides every other event that cycle):
  - `tens`=0, `ovf`=0, `scan_cnt`=0, `sel`=0, `unit_r`=0.
  - `co_d`=1, so a `co_in` still high after reset is not counted.
  - `an`=2'b11 (all digits off), `seg`=7'h00.

## Timing
- Increment latency:
  - `co_in` rises and is sampled at edge k.
  - `tens` shows the new value after edge k; `ovf` is asserted in the same cycle.
- Display latency:
  - A value change (`q_in`, or a `tens` update) reaches `seg` two edges later for units, one edge later for tens.
  - This applies only while that digit is selected.
- First edge after reset release: `an`=2'b10, `seg`=decode(0).
- Each digit is lit for exactly `SCAN_DIV` cycles. Digits alternate with no blank gap, and `an` is never 2'b00.
- Back-to-back `co_in` pulses (1,0,1) count twice. Constant 1 counts once.
- If an increment event and the scan toggle fall in the same cycle, both take effect. `seg` then shows the pre-increment `tens` for one cycle.

## Configuration
- Macro: `CNT_DISP_LZ_BLANK_EN`.
- Defined: while the tens digit is selected and `tens`==0, `seg` is driven 7'h00 (leading-zero blank). The `an` sequence is unchanged.
- Not defined: tens 0 displays as 7'h3F.
- The units digit is never blanked in either build.

## Structure
- Shared package `cnt_disp_pkg` holds:
  - the 16-entry segment constant array (gfedcba encoding);
  - localparams for digit width (4), segment width (7), and the `an` codes for units, tens and off.
- Sub-module `seg7_dec`: purely combinational 4→7 lookup on the package array, instantiated once after the digit mux.
- Top module holds the carry edge detect, tens counter, scan counter, and output registers.

## Test plan
All tests use `SCAN_DIV`=4 and `TENS_MAX`=9.
- **Reset:**
  - Stimulus: hold `mr`=0 for 3 cycles with `co_in`=1.
  - Response: `tens`=0, `ovf`=0, `an`=2'b11, `seg`=7'h00.
  - Release `mr` with `co_in` still 1: no increment; next edge `an`=2'b10.
- **Scan:**
  - Stimulus: `q_in`=7 constant.
  - Response: `an` alternates 2'b10/2'b01 every 4 cycles.
  - `seg`=7'h07 on units. On tens, `seg`=7'h3F (macro off) or 7'h00 (macro on).
- **Held carry:**
  - Stimulus: `co_in`=1 for 6 cycles.
  - Response: `tens` goes 0→1 exactly once, one cycle after the rise.
- **Wrap:**
  - Stimulus: ten single-cycle `co_in` pulses, separated by 0.
  - Response: `tens` steps 1..9 then 0.
  - `ovf`=1 for exactly one cycle, coincident with `tens`=0.
- **Reset mid-operation:**
  - Stimulus: `tens`=5, with `mr`=0 in the same cycle as a `co_in` rising edge.
  - Response: next `tens`=0, not 6; no `ovf`.
- **Hex decode:**
  - Stimulus: `q_in`=4'hC.
  - Response: during the units slot, `seg`=7'h39.
